// File: rtl/rs_enc_parity_gen_pkg.sv
// rs_enc_parity_gen_pkg: RS(32,28) shared constants, FSM encoding and GF(256) helpers.
//   Shared with the decoder stages: generator taps for alpha^0..alpha^3,
//   primitive polynomial 0x11D and the frame geometry.
package rs_enc_parity_gen_pkg;
  localparam int RS_DATA_LEN = 28;
  localparam int RS_PAR_LEN = 4;
  localparam logic [8:0] RS_PRIM_POLY = 9'h11D;
  localparam logic [7:0] RS_G3 = 8'h0F;
  localparam logic [7:0] RS_G2 = 8'h36;
  localparam logic [7:0] RS_G1 = 8'h78;
  localparam logic [7:0] RS_G0 = 8'h40;
  typedef enum logic {ST_DATA, ST_PARITY} enc_state_t;
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ RS_PRIM_POLY[7:0]) : {a[6:0], 1'b0};
  endfunction
endpackage

// File: rtl/rs_enc_parity_gen_gf256.sv
// gf256_mult / gf256_sum: GF(256) constant multiplier and adder cells.
//   gf256_mult: a (8) in, y = a*B (8) out, pure XOR network (Horner over B).
//   gf256_sum : a, b (8) in, y = a^b (8) out.
module gf256_mult
  import rs_enc_parity_gen_pkg::*;
#(
  parameter logic [7:0] B = 8'h01
) (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] acc;
  always_comb begin
    acc = '0;
    for (int i = 7; i >= 0; i--) acc = gf_xtime(acc) ^ (B[i] ? a : 8'h00);
  end
  assign y = acc;
endmodule

module gf256_sum (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/rs_enc_parity_gen_toggle_sync.sv
// rs_enc_toggle_sync: 2-FF synchronizer plus XOR edge detector for a toggle strobe.
//   i_clk, i_resb (sync active-low), i_async: toggle strobe from another domain,
//   o_rdy: one-cycle pulse per strobe edge.
module rs_enc_toggle_sync (
  input  logic i_clk,
  input  logic i_resb,
  input  logic i_async,
  output logic o_rdy
);
  logic s1_q, s1_d, s2_q, s2_d;
  always_comb begin
    s1_d = i_async;
    s2_d = s1_q;
  end
  always_ff @(posedge i_clk) begin
    if (!i_resb) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
  assign o_rdy = s1_q ^ s2_q;
endmodule

// File: rtl/rs_enc_parity_gen.sv
// rs_enc_parity_gen: systematic RS(32,28) encoder, forwards 28 bytes then appends 4 parity bytes.
//   i_clk, i_resb (sync active-low), i_frame_sync: restart frame,
//   i_data/i_data_sync: message byte + toggle strobe (async),
//   o_data/o_data_sync: codeword byte + toggle, o_busy: parity emission,
//   o_frame_done: pulse after last parity byte, o_overrun: sticky dropped-strobe flag.
module rs_enc_parity_gen
  import rs_enc_parity_gen_pkg::*;
#(
  parameter int DATA_LEN = RS_DATA_LEN,
  parameter int OUT_GAP = 4
) (
  input  logic       i_clk,
  input  logic       i_resb,
  input  logic       i_frame_sync,
  input  logic [7:0] i_data,
  input  logic       i_data_sync,
  output logic [7:0] o_data,
  output logic       o_data_sync,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_overrun
);
  localparam int CW = $clog2(DATA_LEN);
  localparam int GW = $clog2(OUT_GAP + 1);
  localparam int PW = $clog2(RS_PAR_LEN + 1);
  enc_state_t state_q, state_d, st_b;
  logic [CW-1:0] cnt_q, cnt_d, cnt_b;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [7:0] p3_q, p2_q, p1_q, p0_q, p3_d, p2_d, p1_d, p0_d;
  logic [7:0] b3, b2, b1, b0, fb, m3, m2, m1, m0, n3, n2, n1;
  logic [7:0] data_q, data_d;
  logic sync_q, sync_d, done_q, done_d, ovr_q, ovr_d;
  logic rx_rdy, last_byte;
  rs_enc_toggle_sync u_sync (
    .i_clk  (i_clk),
    .i_resb (i_resb),
    .i_async(i_data_sync),
    .o_rdy  (rx_rdy)
  );
  // frame_sync restarts from a cleared frame, so a byte arriving in the same
  // cycle is encoded as byte 0 against an all-zero LFSR.
  assign st_b = i_frame_sync ? ST_DATA : state_q;
  assign cnt_b = i_frame_sync ? '0 : cnt_q;
  assign b3 = i_frame_sync ? 8'h00 : p3_q;
  assign b2 = i_frame_sync ? 8'h00 : p2_q;
  assign b1 = i_frame_sync ? 8'h00 : p1_q;
  assign b0 = i_frame_sync ? 8'h00 : p0_q;
  assign last_byte = cnt_b == CW'(DATA_LEN - 1);
  gf256_sum u_fb (.a(i_data), .b(b3), .y(fb));
  gf256_mult #(.B(RS_G3)) u_m3 (.a(fb), .y(m3));
  gf256_mult #(.B(RS_G2)) u_m2 (.a(fb), .y(m2));
  gf256_mult #(.B(RS_G1)) u_m1 (.a(fb), .y(m1));
  gf256_mult #(.B(RS_G0)) u_m0 (.a(fb), .y(m0));
  gf256_sum u_s3 (.a(b2), .b(m3), .y(n3));
  gf256_sum u_s2 (.a(b1), .b(m2), .y(n2));
  gf256_sum u_s1 (.a(b0), .b(m1), .y(n1));
  always_comb begin
    state_d = st_b;
    cnt_d = cnt_b;
    gap_d = i_frame_sync ? '0 : gap_q;
    pcnt_d = i_frame_sync ? '0 : pcnt_q;
    {p3_d, p2_d, p1_d, p0_d} = {b3, b2, b1, b0};
    ovr_d = i_frame_sync ? 1'b0 : ovr_q;
    data_d = data_q;
    sync_d = sync_q;
    done_d = 1'b0;
    if (st_b == ST_DATA) begin
      if (rx_rdy) begin
        data_d = i_data;
        sync_d = ~sync_q;
        {p3_d, p2_d, p1_d, p0_d} = {n3, n2, n1, m0};
        cnt_d = last_byte ? '0 : cnt_b + 1'b1;
        state_d = last_byte ? ST_PARITY : ST_DATA;
        gap_d = last_byte ? GW'(OUT_GAP) : gap_d;
        pcnt_d = '0;
      end
    end else begin
      ovr_d = ovr_q | rx_rdy;
      if (pcnt_q == PW'(RS_PAR_LEN)) begin
        state_d = ST_DATA;
        pcnt_d = '0;
        gap_d = '0;
        done_d = 1'b1;
      end else if (gap_q == GW'(1)) begin
        data_d = p3_q;
        sync_d = ~sync_q;
        {p3_d, p2_d, p1_d, p0_d} = {p2_q, p1_q, p0_q, 8'h00};
        pcnt_d = pcnt_q + 1'b1;
        gap_d = GW'(OUT_GAP);
      end else begin
        gap_d = gap_q - 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_resb) begin
      state_q <= ST_DATA;
      cnt_q <= '0;
      gap_q <= '0;
      pcnt_q <= '0;
      {p3_q, p2_q, p1_q, p0_q} <= '0;
      data_q <= '0;
      sync_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      pcnt_q <= pcnt_d;
      {p3_q, p2_q, p1_q, p0_q} <= {p3_d, p2_d, p1_d, p0_d};
      data_q <= data_d;
      sync_q <= sync_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
    end
  end
  assign o_data = data_q;
  assign o_data_sync = sync_q;
  assign o_busy = state_q == ST_PARITY;
  assign o_frame_done = done_q;
  assign o_overrun = ovr_q;
endmodule

// File: tb/tb_rs_enc_parity_gen.sv
// tb_rs_enc_parity_gen: scoreboard bench for rs_enc_parity_gen with a polynomial-division reference model.
module tb_rs_enc_parity_gen;
  logic i_clk = 1'b0, i_resb = 1'b0, i_frame_sync = 1'b0, i_data_sync = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic [7:0] o_data;
  logic o_data_sync, o_busy, o_frame_done, o_overrun;
  int n_chk = 0, n_fail = 0, exp_done = 0, got_done = 0;
  logic [7:0] exp_q[$], cw[$], msg[$];
  logic [31:0] last_par = '0;
  logic prev_sync = 1'b0;

  always #5 i_clk = ~i_clk;

  rs_enc_parity_gen dut (
    .i_clk(i_clk), .i_resb(i_resb), .i_frame_sync(i_frame_sync),
    .i_data(i_data), .i_data_sync(i_data_sync),
    .o_data(o_data), .o_data_sync(o_data_sync), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_overrun(o_overrun)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  // Reference parity: remainder of m(x)*x^4 divided by g(x), by long division.
  task automatic push_parity();
    logic [7:0] rem[32];
    logic [7:0] g[5];
    logic [7:0] c;
    g = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
    for (int i = 0; i < 32; i++) rem[i] = (i < 28) ? msg[i] : 8'h00;
    for (int i = 0; i < 28; i++) begin
      c = rem[i];
      for (int j = 0; j < 5; j++) rem[i+j] = rem[i+j] ^ gmul(c, g[j]);
    end
    for (int i = 28; i < 32; i++) exp_q.push_back(rem[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_data = b;
    i_data_sync = ~i_data_sync;
    exp_q.push_back(b);
    msg.push_back(b);
    if (msg.size() == 28) begin
      push_parity();
      msg.delete();
    end
    repeat (4) @(negedge i_clk);
  endtask

  task automatic finish_frame();
    exp_done++;
    for (int i = 0; i < 200; i++) begin
      if (!o_busy && exp_q.size() == 0) break;
      @(negedge i_clk);
    end
    @(negedge i_clk);
    chk("frame_idle_busy", 32'(o_busy), 32'h0);
    chk("frame_pending_bytes", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_o_data", 32'(o_data), 32'h0);
    chk("rst_o_data_sync", 32'(o_data_sync), 32'h0);
    chk("rst_o_busy", 32'(o_busy), 32'h0);
    chk("rst_o_frame_done", 32'(o_frame_done), 32'h0);
    chk("rst_o_overrun", 32'(o_overrun), 32'h0);
  endtask

  // Monitor: pops the scoreboard on every output toggle; on frame_done the
  // collected codeword must evaluate to zero at alpha^0..alpha^3.
  always @(negedge i_clk) begin
    logic [7:0] s, e;
    if (!i_resb) begin
      prev_sync = o_data_sync;
    end else begin
      if (o_data_sync !== prev_sync) begin
        prev_sync = o_data_sync;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h required none", o_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_byte", 32'(o_data), 32'(e));
        end
        cw.push_back(o_data);
      end
      if (o_frame_done) begin
        got_done++;
        chk("codeword_len", 32'(cw.size()), 32'd32);
        if (cw.size() == 32) begin
          for (int j = 0; j < 4; j++) begin
            s = 8'h00;
            for (int k = 0; k < 32; k++) s = gmul(s, 8'(1 << j)) ^ cw[k];
            chk($sformatf("syndrome_S%0d", j), 32'(s), 32'h0);
          end
          last_par = {cw[28], cw[29], cw[30], cw[31]};
        end
        cw.delete();
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    repeat (3) @(negedge i_clk);
    check_reset_outputs();
    i_resb = 1'b1;
    repeat (2) @(negedge i_clk);
    // Zero message
    for (int i = 0; i < 28; i++) send_byte(8'h00);
    finish_frame();
    chk("zero_parity", last_par, 32'h00000000);
    // Impulse in last byte
    for (int i = 0; i < 28; i++) send_byte(i == 27 ? 8'h01 : 8'h00);
    finish_frame();
    chk("impulse_parity", last_par, 32'h0F367840);
    // Linearity
    for (int i = 0; i < 28; i++) send_byte(i == 27 ? 8'h02 : 8'h00);
    finish_frame();
    chk("linear_parity", last_par, 32'h1E6CF080);
    // Random back-to-back frames
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 28; i++) send_byte(8'($urandom));
      finish_frame();
    end
    // Overrun then abort mid-parity
    for (int i = 0; i < 28; i++) send_byte(8'($urandom));
    chk("busy_in_parity", 32'(o_busy), 32'h1);
    i_data = 8'hA5;
    i_data_sync = ~i_data_sync;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() <= 2) break;
      @(negedge i_clk);
    end
    chk("abort_point_pending", 32'(exp_q.size()), 32'd2);
    chk("overrun_set", 32'(o_overrun), 32'h1);
    done_before = got_done;
    i_frame_sync = 1'b1;
    @(negedge i_clk);
    i_frame_sync = 1'b0;
    exp_q.delete();
    cw.delete();
    chk("abort_busy", 32'(o_busy), 32'h0);
    chk("abort_overrun", 32'(o_overrun), 32'h0);
    repeat (30) @(negedge i_clk);
    chk("abort_no_done", 32'(got_done), 32'(done_before));
    for (int i = 0; i < 28; i++) send_byte(8'($urandom));
    finish_frame();
    // Reset mid-frame
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    i_resb = 1'b0;
    i_data_sync = 1'b0;
    repeat (2) @(negedge i_clk);
    check_reset_outputs();
    chk("reset_pending", 32'(exp_q.size()), 32'h0);
    msg.delete();
    cw.delete();
    i_resb = 1'b1;
    repeat (2) @(negedge i_clk);
    for (int i = 0; i < 28; i++) send_byte(8'($urandom));
    finish_frame();
    repeat (10) @(negedge i_clk);
    chk("frame_done_count", 32'(got_done), 32'(exp_done));
    chk("final_pending", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_enc_parity_gen.md
Name: rs_enc_parity_gen

Overview:
RS(32,28) encoder for the CD path, the transmit-side counterpart of the decoder syndrome stage. It accepts 28 message bytes over the toggle-strobe byte interface and forwards each one unchanged. It then appends 4 parity bytes computed with a systematic LFSR over GF(256) (primitive poly 0x11D, roots α^0..α^3). Its output stream is a 32-byte codeword that the decoder syndrome stage must reduce to all-zero syndromes.

Parameters:
- DATA_LEN, 28: message bytes per frame.
- PAR_LEN, 4: parity bytes per frame. Fixed by the generator; not user-changeable.
- OUT_GAP, 4: clock cycles between consecutive parity byte emissions. Minimum 1.

Ports:
- i_clk  in  1  system clock.
- i_resb  in  1  reset, synchronous, active-low.
- i_frame_sync  in  1  synchronous pulse that starts a new frame.
- i_data  in  8  message byte.
- i_data_sync  in  1  toggle strobe. Each edge marks a new i_data. Asynchronous to i_clk.
- o_data  out  8  codeword byte.
- o_data_sync  out  1  toggles once per o_data byte.
- o_busy  out  1  high while parity bytes are being emitted.
- o_frame_done  out  1  one-cycle pulse after the last parity byte.
- o_overrun  out  1  sticky flag: an input strobe arrived while o_busy was high.

Behaviour:
- Reset (i_resb=0 at posedge): all outputs 0, parity regs p0..p3 = 0, byte counter = 0, FSM = DATA. The 2-FF strobe synchronizer is also cleared.
- Strobe detect: i_data_sync passes through a 2-FF synchronizer. rx_rdy = XOR of the two stages. i_data is stable for ≥3 cycles after the strobe edge.
- Generator polynomial: g(x) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40.
- LFSR update per accepted byte in DATA state, with fb = i_data ^ p3:
  - p3 <= p2 ^ fb·0x0F
  - p2 <= p1 ^ fb·0x36
  - p1 <= p0 ^ fb·0x78
  - p0 <= fb·0x40
- DATA state, rx_rdy high in cycle k: at edge k+1, o_data = i_data, o_data_sync toggles, LFSR updates, counter increments.
- On the 28th byte: counter resets to 0, FSM -> PARITY, gap counter loaded.
- PARITY state:
  - p3, p2, p1, p0 are emitted in that order, the first OUT_GAP cycles after the 28th byte is output, then every OUT_GAP cycles. Each emission toggles o_data_sync.
  - Parity regs shift toward p3 on each emission, with 0 shifted into p0.
  - The cycle after the 4th emission: o_frame_done=1 for 1 cycle, FSM -> DATA, parity regs are all 0.
  - o_busy = 1 exactly while FSM = PARITY.
- Strobes during PARITY are dropped (no output, no LFSR change) and set o_overrun.
- i_frame_sync (priority: reset > frame_sync > strobe):
  - Clears counter, parity regs, gap counter and o_overrun. FSM -> DATA.
  - Aborts PARITY mid-frame with no o_frame_done.
  - If rx_rdy is high in the same cycle, the byte is accepted as byte 0 of the new frame, using the cleared LFSR.
- No frame_sync is required between frames: the counter wraps 27 -> 0 automatically.
- GF multiplies by constants are pure combinational XOR networks; there is no multiplier state.

Decomposition:
- Shared package: the generator coefficients (0x0F, 0x36, 0x78, 0x40), primitive poly 0x11D, and the DATA_LEN/PAR_LEN constants. This package is shared with the decoder stages.
- Reuse the existing gf256_mult (constant B) and gf256_sum cells for the LFSR taps.
- Natural sub-module: rs_enc_toggle_sync, holding the 2-FF synchronizer and XOR edge detector. The decoder side should adopt it too.

Test Plan:
- Zero message: 28 bytes 0x00 -> output 28×0x00 then parity 0x00,0x00,0x00,0x00, o_frame_done pulse, 32 o_data_sync toggles.
- Impulse: bytes 0..26 = 0x00, byte 27 = 0x01 -> parity 0x0F,0x36,0x78,0x40. The codeword fed to the syndrome calc must give S0..S3 = 0.
- Linearity: byte 27 = 0x02, others 0 -> parity 0x1E,0x6C,0xF0,0x80.
- Random messages (≥100 frames, back-to-back, no frame_sync) -> check parity against a reference model, and check the decoder syndromes are all zero.
- Overrun/abort:
  - Strobe during PARITY -> o_overrun=1, output unchanged.
  - Then i_frame_sync mid-parity -> no o_frame_done, o_busy=0, o_overrun=0, next frame is encoded correctly.
- Reset mid-frame: i_resb=0 after byte 10 -> all outputs 0. The next 28-byte frame produces correct parity.
